// File: rtl/miriscv_lsu_bus.sv
// Load/store unit bridging one core access to one granted data-bus transaction.
// Handles lane steering, load extension, alignment/size traps, bus errors and a response timeout.
`ifndef LDST_B
`define LDST_B  3'd0
`define LDST_H  3'd1
`define LDST_W  3'd2
`define LDST_D  3'd3
`define LDST_BU 3'd4
`define LDST_HU 3'd5
`endif

module miriscv_lsu_bus #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                arstn_i,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [2:0]          lsu_size_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_data_i,
    output logic                lsu_stall_req_o,
    output logic [DATA_W-1:0]   lsu_data_o,
    output logic                lsu_misalign_o,
    output logic                lsu_err_o,
    output logic                data_req_o,
    input  logic                data_gnt_i,
    output logic                data_we_o,
    output logic [DATA_W/8-1:0] data_be_o,
    output logic [ADDR_W-1:0]   data_addr_o,
    output logic [DATA_W-1:0]   data_wdata_o,
    input  logic                data_rvalid_i,
    input  logic [DATA_W-1:0]   data_rdata_i,
    input  logic                data_err_i,
    output logic [1:0]          lsu_state_o
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFS_W = $clog2(BE_W);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    state_t            state;
    logic [15:0]       cnt;
    logic              we_q;
    logic [2:0]        size_q;
    logic [OFS_W-1:0]  ofs_q;

    logic [1:0]        sz_c;
    logic [7:0]        mask8_c;
    logic [2:0]        align3_c;
    logic [OFS_W-1:0]  ofs_c;
    logic [OFS_W-1:0]  lane_c;
    logic              illegal_c;
    logic              misalign_c;
    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] shifted_c;
    logic [DATA_W-1:0] ext_c;
    logic              tmo_c;

    always_comb begin
        sz_c     = lsu_size_i[1:0];
        ofs_c    = lsu_addr_i[OFS_W-1:0];
        mask8_c  = 8'h01;
        align3_c = 3'd0;
        case (sz_c)
            2'd0: begin mask8_c = 8'h01; align3_c = 3'd0; end
            2'd1: begin mask8_c = 8'h03; align3_c = 3'd1; end
            2'd2: begin mask8_c = 8'h0F; align3_c = 3'd3; end
            default: begin mask8_c = 8'hFF; align3_c = 3'd7; end
        endcase
        illegal_c  = (lsu_size_i > `LDST_HU) || ((lsu_size_i == `LDST_D) && (DATA_W == 32));
        misalign_c = (ofs_c & OFS_W'(align3_c)) != '0;
        be_c       = BE_W'(mask8_c) << ofs_c;
        // Each lane takes the store byte at its position modulo the access size.
        wdata_c = '0;
        lane_c  = '0;
        for (int i = 0; i < BE_W; i++) begin
            lane_c = OFS_W'(i) & OFS_W'(align3_c);
            wdata_c[8*i +: 8] = lsu_data_i[8*lane_c +: 8];
        end
    end

    always_comb begin
        shifted_c = data_rdata_i >> {ofs_q, 3'b000};
        ext_c     = shifted_c;
        case (size_q)
            `LDST_B:  ext_c = DATA_W'($signed(shifted_c[7:0]));
            `LDST_BU: ext_c = DATA_W'(shifted_c[7:0]);
            `LDST_H:  ext_c = DATA_W'($signed(shifted_c[15:0]));
            `LDST_HU: ext_c = DATA_W'(shifted_c[15:0]);
            `LDST_W:  ext_c = DATA_W'($signed(shifted_c[31:0]));
            default:  ext_c = shifted_c;
        endcase
        tmo_c = (TIMEOUT != 0) && ((cnt + 16'd1) == 16'(TIMEOUT));
    end

    always_comb begin
        case (state)
            IDLE:    lsu_stall_req_o = lsu_req_i;
            REQ:     lsu_stall_req_o = 1'b1;
            WAIT:    lsu_stall_req_o = 1'b1;
            default: lsu_stall_req_o = 1'b0;
        endcase
    end

    assign lsu_state_o = state;

    // Bus handshake: data_req_o is raised with stable we/be/addr/wdata and held until a cycle
    // in which data_gnt_i is high; exactly one data_rvalid_i response follows per grant.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state          <= IDLE;
            cnt            <= '0;
            we_q           <= 1'b0;
            size_q         <= '0;
            ofs_q          <= '0;
            data_req_o     <= 1'b0;
            data_we_o      <= 1'b0;
            data_be_o      <= '0;
            data_addr_o    <= '0;
            data_wdata_o   <= '0;
            lsu_data_o     <= '0;
            lsu_err_o      <= 1'b0;
            lsu_misalign_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_req_i) begin
                        we_q         <= lsu_we_i;
                        size_q       <= lsu_size_i;
                        ofs_q        <= ofs_c;
                        data_we_o    <= lsu_we_i;
                        data_be_o    <= be_c;
                        data_addr_o  <= {lsu_addr_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                        data_wdata_o <= wdata_c;
                        if (illegal_c) begin
                            state     <= DONE;
                            lsu_err_o <= 1'b1;
                        end else if (misalign_c) begin
                            state          <= DONE;
                            lsu_misalign_o <= 1'b1;
                        end else begin
                            state      <= REQ;
                            data_req_o <= 1'b1;
                            cnt        <= '0;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 16'd1;
                    if (data_gnt_i) begin
                        state      <= WAIT;
                        data_req_o <= 1'b0;
                    end else if (tmo_c) begin
                        state      <= DONE;
                        data_req_o <= 1'b0;
                        lsu_err_o  <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (data_rvalid_i) begin
                        state      <= DONE;
                        lsu_err_o  <= data_err_i;
                        lsu_data_o <= we_q ? '0 : ext_c;
                    end else if (tmo_c) begin
                        state     <= DONE;
                        lsu_err_o <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    lsu_data_o     <= '0;
                    lsu_err_o      <= 1'b0;
                    lsu_misalign_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_miriscv_lsu_bus.sv
// Directed bench for miriscv_lsu_bus: 32-bit bus, plus a second instance with a short timeout.
module tb_miriscv_lsu_bus;
    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        lsu_req = 1'b0, req_t = 1'b0, lsu_we = 1'b0;
    logic [2:0]  lsu_size = '0;
    logic [31:0] lsu_addr = '0, lsu_data = '0;
    logic        data_gnt = 1'b0, data_rvalid = 1'b0, data_err = 1'b0;
    logic [31:0] data_rdata = '0;

    logic        lsu_stall, lsu_mis, lsu_err, data_req, data_we;
    logic [31:0] lsu_dout, data_addr, data_wdata;
    logic [3:0]  data_be;
    logic [1:0]  state;

    logic        stall_t, mis_t, err_t, req_o_t, we_t;
    logic [31:0] dout_t, addr_t, wdata_t;
    logic [3:0]  be_t;
    logic [1:0]  state_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    miriscv_lsu_bus #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(255)) dut (
        .clk_i(clk), .arstn_i(arstn), .lsu_req_i(lsu_req), .lsu_we_i(lsu_we),
        .lsu_size_i(lsu_size), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
        .lsu_stall_req_o(lsu_stall), .lsu_data_o(lsu_dout), .lsu_misalign_o(lsu_mis),
        .lsu_err_o(lsu_err), .data_req_o(data_req), .data_gnt_i(data_gnt),
        .data_we_o(data_we), .data_be_o(data_be), .data_addr_o(data_addr),
        .data_wdata_o(data_wdata), .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
        .data_err_i(data_err), .lsu_state_o(state)
    );

    miriscv_lsu_bus #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut_t (
        .clk_i(clk), .arstn_i(arstn), .lsu_req_i(req_t), .lsu_we_i(lsu_we),
        .lsu_size_i(lsu_size), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
        .lsu_stall_req_o(stall_t), .lsu_data_o(dout_t), .lsu_misalign_o(mis_t),
        .lsu_err_o(err_t), .data_req_o(req_o_t), .data_gnt_i(data_gnt),
        .data_we_o(we_t), .data_be_o(be_t), .data_addr_o(addr_t),
        .data_wdata_o(wdata_t), .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
        .data_err_i(data_err), .lsu_state_o(state_t)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic run_access(input string tag, input logic we, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] sdata, input int gnt_wait,
                              input logic [31:0] rdata, input logic berr, input logic [3:0] exp_be,
                              input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_data, input logic exp_err);
        int stalls;
        int req_cyc;
        logic fld_ok;
        logic [31:0] exp_d;
        exp_q.push_back(exp_data);
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_data = sdata;
        #1;
        stalls  = lsu_stall ? 1 : 0;
        req_cyc = 0;
        fld_ok  = 1'b1;
        for (int k = 0; k <= gnt_wait; k++) begin
            @(negedge clk);
            if (lsu_stall) stalls++;
            if (data_req) req_cyc++;
            fld_ok &= (data_req === 1'b1) && (data_we === we) && (data_be === exp_be) &&
                      (data_addr === exp_addr) && (data_wdata === exp_wdata);
            data_gnt = (k == gnt_wait);
        end
        @(negedge clk);
        data_gnt = 1'b0;
        if (lsu_stall) stalls++;
        check({tag, "_req_drop"}, {63'd0, data_req}, 64'd0);
        data_rvalid = 1'b1; data_rdata = rdata; data_err = berr;
        @(negedge clk);
        exp_d = exp_q.pop_front();
        check({tag, "_fields"}, {63'd0, fld_ok}, 64'd1);
        check({tag, "_req_cycles"}, 64'(req_cyc), 64'(gnt_wait + 1));
        check({tag, "_stall_cycles"}, 64'(stalls), 64'(gnt_wait + 3));
        check({tag, "_data"}, {32'd0, lsu_dout}, {32'd0, exp_d});
        check({tag, "_err"}, {63'd0, lsu_err}, {63'd0, exp_err});
        check({tag, "_done_stall"}, {62'd0, lsu_stall, lsu_mis}, 64'd0);
        data_rvalid = 1'b0; data_err = 1'b0; data_rdata = '0; lsu_req = 1'b0;
        @(negedge clk);
        check({tag, "_clear"}, {29'd0, state, lsu_err, lsu_dout}, 64'd0);
    endtask

    task automatic run_trap(input string tag, input logic [2:0] size, input logic [31:0] addr,
                            input logic exp_err, input logic exp_mis);
        logic req_seen;
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = size; lsu_addr = addr;
        #1;
        check({tag, "_stall"}, {63'd0, lsu_stall}, 64'd1);
        req_seen = data_req;
        @(negedge clk);
        req_seen |= data_req;
        check({tag, "_done"}, {60'd0, state, lsu_err, lsu_mis}, {60'd0, 2'd3, exp_err, exp_mis});
        check({tag, "_no_req"}, {62'd0, req_seen, lsu_stall}, 64'd0);
        lsu_req = 1'b0;
        @(negedge clk);
        check({tag, "_clear"}, {60'd0, state, lsu_err, lsu_mis}, 64'd0);
    endtask

    initial begin
        int cyc;
        logic done;
        #2;
        check("reset_bus", {data_req, data_we, data_be, data_addr, 26'd0}, 64'd0);
        check("reset_core", {data_wdata, lsu_dout}, 64'd0);
        check("reset_flags", {60'd0, state, lsu_err, lsu_mis}, 64'd0);
        @(negedge clk);
        arstn = 1'b1;

        run_access("lw",  1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
        run_access("lb",  1'b0, 3'd0, 32'h103, 32'h0, 0, 32'h80FF0000, 1'b0, 4'h8, 32'h100, 32'h0, 32'hFFFFFF80, 1'b0);
        run_access("lbu", 1'b0, 3'd4, 32'h103, 32'h0, 0, 32'h80FF0000, 1'b0, 4'h8, 32'h100, 32'h0, 32'h00000080, 1'b0);
        run_access("lhu", 1'b0, 3'd5, 32'h102, 32'h0, 0, 32'h80FF0000, 1'b0, 4'hC, 32'h100, 32'h0, 32'h000080FF, 1'b0);
        run_access("lh",  1'b0, 3'd1, 32'h102, 32'h0, 0, 32'h80FF0000, 1'b0, 4'hC, 32'h100, 32'h0, 32'hFFFF80FF, 1'b0);
        run_access("sb",  1'b1, 3'd0, 32'h201, 32'h12345678, 0, 32'hAAAAAAAA, 1'b0, 4'h2, 32'h200, 32'h78787878, 32'h0, 1'b0);
        run_access("sh",  1'b1, 3'd1, 32'h202, 32'h0000BEEF, 1, 32'h0, 1'b0, 4'hC, 32'h200, 32'hBEEFBEEF, 32'h0, 1'b0);
        run_access("bp",  1'b0, 3'd2, 32'h304, 32'h0, 5, 32'h12345678, 1'b0, 4'hF, 32'h304, 32'h0, 32'h12345678, 1'b0);
        run_access("berr", 1'b0, 3'd2, 32'h108, 32'h0, 0, 32'h0, 1'b1, 4'hF, 32'h108, 32'h0, 32'h0, 1'b1);

        run_trap("mis_h", 3'd1, 32'h101, 1'b0, 1'b1);
        run_trap("mis_w", 3'd2, 32'h102, 1'b0, 1'b1);
        run_trap("ill_d", 3'd3, 32'h100, 1'b1, 1'b0);
        run_trap("ill_7", 3'd7, 32'h100, 1'b1, 1'b0);

        // Timeout: grant never comes on the short-timeout instance.
        @(negedge clk);
        req_t = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h400;
        cyc = 0; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (req_o_t) cyc++;
            if (state_t == 2'd3) begin
                done = 1'b1;
                check("tmo_err", {63'd0, err_t}, 64'd1);
            end
        end
        check("tmo_done", {63'd0, done}, 64'd1);
        check("tmo_req_cycles", 64'(cyc), 64'd4);
        req_t = 1'b0;
        @(negedge clk);
        check("tmo_clear", {61'd0, err_t, state_t}, 64'd0);

        // Reset while waiting for the response.
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 3'd2; lsu_addr = 32'h500; lsu_data = 32'hCAFEF00D;
        @(negedge clk);
        data_gnt = 1'b1;
        @(negedge clk);
        data_gnt = 1'b0;
        check("rst_wait_state", {62'd0, state}, 64'd2);
        #2 arstn = 1'b0;
        #1;
        check("rst_wait_bus", {data_we, data_be, data_addr, 27'd0}, 64'd0);
        check("rst_wait_core", {data_wdata, 30'd0, state}, 64'd0);
        lsu_req = 1'b0;
        @(negedge clk);
        arstn = 1'b1;

        // Reset while requesting: data_req_o must drop without a clock edge.
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h600;
        @(negedge clk);
        check("rst_req_pre", {63'd0, data_req}, 64'd1);
        #2 arstn = 1'b0;
        #1;
        check("rst_req_async", {61'd0, data_req, state}, 64'd0);
        lsu_req = 1'b0;
        @(negedge clk);
        arstn = 1'b1;

        run_access("post_rst", 1'b0, 3'd2, 32'h104, 32'h0, 0, 32'h89ABCDEF, 1'b0, 4'hF, 32'h104, 32'h0, 32'h89ABCDEF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
